// File: rtl/ysyx_220066_if.sv
// Instruction fetch stage: single-outstanding fetch FSM with a one-entry skid buffer.
// Optional feature: YSYX_220066_IF_PERF_EN adds the fetch_cnt counter of consumed instructions.
module ysyx_220066_if #(
  parameter logic [63:0] RST_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        valid_out,
  output logic [31:0] instr,
  output logic [63:0] pc_out,
  output logic        instr_error
`ifdef YSYX_220066_IF_PERF_EN
  , output logic [63:0] fetch_cnt
`endif
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic              drop;
  logic              skid_valid;
  logic [ILEN-1:0]   skid_instr;
  logic [XLEN-1:0]   skid_pc;
  logic              skid_err;
  logic              slot_free;
  logic              consumed;

  assign imem_addr = fetch_pc;
  assign slot_free = !valid_out || !block;
  assign consumed  = valid_out && !block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RST_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      valid_out   <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      instr_error <= 1'b0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_err    <= 1'b0;
`ifdef YSYX_220066_IF_PERF_EN
      fetch_cnt   <= '0;
`endif
    end else begin
      // Decode took the held instruction; any load below overrides this clear.
      if (consumed) valid_out <= 1'b0;
`ifdef YSYX_220066_IF_PERF_EN
      if (consumed) fetch_cnt <= fetch_cnt + XLEN'(1);
`endif
      if (redirect) begin
        fetch_pc   <= redirect_pc;
        valid_out  <= 1'b0;
        skid_valid <= 1'b0;
        if (state == WAIT && !skid_valid && !imem_rvalid) begin
          // A response is still in flight: wait for it and throw it away.
          drop     <= 1'b1;
          imem_req <= 1'b0;
        end else if (state == REQ && imem_req && imem_gnt) begin
          state    <= WAIT;
          drop     <= 1'b1;
          imem_req <= 1'b0;
        end else begin
          state    <= REQ;
          drop     <= 1'b0;
          imem_req <= (redirect_pc[1:0] == 2'b00);
        end
      end else begin
        case (state)
          IDLE: begin
            state    <= REQ;
            imem_req <= (fetch_pc[1:0] == 2'b00);
          end
          REQ: begin
            if (fetch_pc[1:0] != 2'b00) begin
              // Misaligned target: hand decode a faulting nop instead of fetching.
              if (slot_free) begin
                valid_out   <= 1'b1;
                instr       <= NOP;
                pc_out      <= fetch_pc;
                instr_error <= 1'b1;
                imem_req    <= 1'b0;
                state       <= HALT;
              end
            end else if (imem_req && imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (skid_valid) begin
              if (!block) begin
                valid_out   <= 1'b1;
                instr       <= skid_instr;
                pc_out      <= skid_pc;
                instr_error <= skid_err;
                skid_valid  <= 1'b0;
                state       <= skid_err ? HALT : REQ;
                imem_req    <= !skid_err;
              end
            end else if (imem_rvalid) begin
              if (drop) begin
                drop     <= 1'b0;
                state    <= REQ;
                imem_req <= (fetch_pc[1:0] == 2'b00);
              end else begin
                fetch_pc <= fetch_pc + XLEN'(4);
                if (slot_free) begin
                  valid_out   <= 1'b1;
                  instr       <= imem_rdata;
                  pc_out      <= fetch_pc;
                  instr_error <= imem_err;
                  state       <= imem_err ? HALT : REQ;
                  imem_req    <= !imem_err;
                end else begin
                  skid_valid <= 1'b1;
                  skid_instr <= imem_rdata;
                  skid_pc    <= fetch_pc;
                  skid_err   <= imem_err;
                end
              end
            end
          end
          default: begin
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220066_if.sv
// Directed bench for ysyx_220066_if: inputs driven and outputs sampled on the falling clock edge.
module tb_ysyx_220066_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        block = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        valid_out;
  logic [31:0] instr;
  logic [63:0] pc_out;
  logic        instr_error;
`ifdef YSYX_220066_IF_PERF_EN
  logic [63:0] fetch_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  ysyx_220066_if dut (
    .clk(clk), .rst(rst), .block(block), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .valid_out(valid_out), .instr(instr), .pc_out(pc_out), .instr_error(instr_error)
`ifdef YSYX_220066_IF_PERF_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({imem_req, valid_out, instr, pc_out, instr_error} !== {1'b0, 1'b0, 32'h0, 64'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b v=%b i=%h pc=%h e=%b, want all zero",
               imem_req, valid_out, instr, pc_out, instr_error);
    end
    checks++;
    if (imem_addr !== 64'h8000_0000) begin
      fails++; $display("FAIL reset_addr: got %h want 80000000", imem_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_0000}) begin
      fails++; $display("FAIL first_req: got req=%b addr=%h want 1/80000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL req_drop_after_gnt: got %b want 0", imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if ({valid_out, instr, pc_out, instr_error} !== {1'b1, 32'h0000_0093, 64'h8000_0000, 1'b0}) begin
      fails++;
      $display("FAIL first_instr: got v=%b i=%h pc=%h e=%b want 1/00000093/80000000/0",
               valid_out, instr, pc_out, instr_error);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_0004}) begin
      fails++; $display("FAIL next_addr: got req=%b addr=%h want 1/80000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_block();
    block = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({valid_out, instr, pc_out, imem_req} !== {1'b1, 32'h0000_0093, 64'h8000_0000, 1'b0}) begin
        fails++;
        $display("FAIL block_frozen[%0d]: got v=%b i=%h pc=%h req=%b want 1/00000093/80000000/0",
                 i, valid_out, instr, pc_out, imem_req);
      end
      if (i == 0) tick();
    end
    block = 1'b0;
    tick();
    checks++;
    if ({valid_out, instr, pc_out, instr_error} !== {1'b1, 32'h0000_0113, 64'h8000_0004, 1'b0}) begin
      fails++;
      $display("FAIL skid_out: got v=%b i=%h pc=%h e=%b want 1/00000113/80000004/0",
               valid_out, instr, pc_out, instr_error);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_0008}) begin
      fails++; $display("FAIL skid_next_addr: got req=%b addr=%h want 1/80000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect = 1'b0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b0, 64'h8000_1000}) begin
      fails++;
      $display("FAIL redirect_wait: got v=%b req=%b addr=%h want 0/0/80001000", valid_out, imem_req, imem_addr);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h8000_1000}) begin
      fails++;
      $display("FAIL drop_response: got v=%b req=%b addr=%h want 0/1/80001000", valid_out, imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    // Redirect coincides with a response: the response must be discarded.
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0001;
    redirect = 1'b1; redirect_pc = 64'h8000_0002;
    tick();
    imem_rvalid = 1'b0; redirect = 1'b0;
    checks++;
    if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b0, 64'h8000_0002}) begin
      fails++;
      $display("FAIL redirect_beats_rvalid: got v=%b req=%b addr=%h want 0/0/80000002", valid_out, imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({valid_out, instr, pc_out, instr_error, imem_req} !== {1'b1, 32'h0000_0013, 64'h8000_0002, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL misaligned_nop: got v=%b i=%h pc=%h e=%b req=%b want 1/00000013/80000002/1/0",
               valid_out, instr, pc_out, instr_error, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid_out, imem_req} !== 2'b00) begin
        fails++; $display("FAIL halt_idle[%0d]: got v=%b req=%b want 0/0", i, valid_out, imem_req);
      end
    end
  endtask

  task automatic test_error();
    redirect = 1'b1; redirect_pc = 64'h8000_2000;
    tick();
    redirect = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_2000}) begin
      fails++; $display("FAIL halt_exit: got req=%b addr=%h want 1/80002000", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0007;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    checks++;
    if ({valid_out, instr, pc_out, imem_addr} !== {1'b1, 32'h0000_0007, 64'h8000_2000, 64'h8000_2004}) begin
      fails++;
      $display("FAIL pre_error_fetch: got v=%b i=%h pc=%h addr=%h want 1/00000007/80002000/80002004",
               valid_out, instr, pc_out, imem_addr);
    end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'h0000_0005;
    tick();
    imem_rvalid = 1'b0; imem_err = 1'b0;
    checks++;
    if ({valid_out, instr, pc_out, instr_error, imem_req} !== {1'b1, 32'h0000_0005, 64'h8000_2004, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL bus_error: got v=%b i=%h pc=%h e=%b req=%b want 1/00000005/80002004/1/0",
               valid_out, instr, pc_out, instr_error, imem_req);
    end
    tick();
    checks++;
    if ({valid_out, imem_req} !== 2'b00) begin
      fails++; $display("FAIL error_halt: got v=%b req=%b want 0/0", valid_out, imem_req);
    end
`ifdef YSYX_220066_IF_PERF_EN
    checks++;
    if (fetch_cnt !== 64'd5) begin
      fails++; $display("FAIL fetch_cnt: got %0d want 5", fetch_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_00b3;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if ({valid_out, instr, pc_out, imem_req, imem_addr} !==
        {1'b1, 32'h0000_00b3, 64'hffff_ffff_ffff_fffc, 1'b1, 64'h0}) begin
      fails++;
      $display("FAIL pc_wrap: got v=%b i=%h pc=%h req=%b addr=%h want 1/000000b3/fffffffffffffffc/1/0",
               valid_out, instr, pc_out, imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_block();
    test_redirect();
    test_misaligned();
    test_error();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
